// File: rtl/hub_row_fetch.sv
// hub_row_fetch: fetches one display row, one pixel per cycle, from a
// pixel-serial frame buffer into a shadow register, then commits the whole row
// to row_out in a single cycle so display_control never sees a partial row.
// The block also owns front/back buffer selection. A swap is applied only at
// the start of a row-0 fetch, which is the frame boundary.
// Optional feature macro: FB_DOUBLE_BUF_EN. When it is defined, double
// buffering and the swap handshake are built. When it is undefined,
// front_sel is tied to 0 and swap_req is ignored.
module hub_row_fetch #(
  parameter int COLOR_COUNT   = 3,
  parameter int COLOR_BITS    = 4,
  parameter int COL_ADDR_BITS = 6,
  parameter int ROW_ADDR_BITS = 4,
  localparam int ROW_ELEM        = 2 ** COL_ADDR_BITS,
  localparam int PIX_W           = COLOR_BITS * COLOR_COUNT,
  localparam int COLOR_DAT_WIDTH = ROW_ELEM * COLOR_BITS,
  localparam int ROW_DAT_WIDTH   = COLOR_DAT_WIDTH * COLOR_COUNT,
  localparam int FB_AW           = 1 + ROW_ADDR_BITS + COL_ADDR_BITS
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [ROW_ADDR_BITS-1:0] next_row,
  output logic [ROW_DAT_WIDTH-1:0] row_out,
  output logic                     row_valid,
  output logic                     row_loaded,
  output logic                     busy,
  output logic                     fb_rd_en,
  output logic [FB_AW-1:0]         fb_addr,
  input  logic [PIX_W-1:0]         fb_rd_data,
  input  logic                     swap_req,
  output logic                     swap_ack,
  output logic                     front_sel
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_COMMIT} state_t;

  localparam logic [COL_ADDR_BITS-1:0] COL_LAST = {COL_ADDR_BITS{1'b1}};
  localparam logic [COL_ADDR_BITS-1:0] COL_ONE  = {{(COL_ADDR_BITS-1){1'b0}}, 1'b1};

  state_t                   r_state;
  logic [ROW_ADDR_BITS-1:0] r_fetch_row;
  logic [ROW_ADDR_BITS-1:0] r_fetched_row;
  logic [COL_ADDR_BITS-1:0] r_col;
  logic                     r_cap_v;
  logic [COL_ADDR_BITS-1:0] r_cap_col;
  logic [ROW_DAT_WIDTH-1:0] r_shadow;
  logic [ROW_DAT_WIDTH-1:0] r_row_out;
  logic                     r_row_valid;
  logic                     r_row_loaded;
  logic                     r_busy;
  logic                     r_rd_en;
  logic [FB_AW-1:0]         r_addr;

  logic                     w_start;
  logic                     w_front_sel;
  logic                     w_sel_start;
  logic [COL_ADDR_BITS-1:0] w_col_nxt;

  // A fetch starts whenever nothing is committed yet or the wanted row differs.
  assign w_start   = (r_state == S_IDLE) && (!r_row_valid || (next_row != r_fetched_row));
  assign w_col_nxt = r_col + COL_ONE;

`ifdef FB_DOUBLE_BUF_EN
  logic r_front_sel;
  logic r_swap_pend;
  logic r_swap_ack;
  logic w_swap_now;

  // A pending or same-edge request is honoured only at a row-0 fetch start.
  assign w_swap_now  = w_start && (next_row == {ROW_ADDR_BITS{1'b0}}) && (r_swap_pend || swap_req);
  // The row-0 fetch that applies the swap already reads from the new front buffer.
  assign w_sel_start = r_front_sel ^ w_swap_now;
  assign w_front_sel = r_front_sel;
  assign swap_ack    = r_swap_ack;

  // Swap bookkeeping: sticky request, buffer toggle and one-cycle acknowledge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_front_sel <= 1'b0;
      r_swap_pend <= 1'b0;
      r_swap_ack  <= 1'b0;
    end else begin
      r_swap_ack <= w_swap_now;
      if (w_swap_now) begin
        r_front_sel <= ~r_front_sel;
        r_swap_pend <= 1'b0;
      end else if (swap_req) begin
        r_swap_pend <= 1'b1;
      end else begin
        r_swap_pend <= r_swap_pend;
      end
    end
  end
`else
  logic w_unused_swap_req;

  assign w_unused_swap_req = swap_req;
  assign w_front_sel       = 1'b0;
  assign w_sel_start       = 1'b0;
  assign swap_ack          = 1'b0;
`endif

  // Fetch sequencer: address generation, read strobe and atomic row commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_fetch_row   <= {ROW_ADDR_BITS{1'b0}};
      r_fetched_row <= {ROW_ADDR_BITS{1'b0}};
      r_col         <= {COL_ADDR_BITS{1'b0}};
      r_row_out     <= {ROW_DAT_WIDTH{1'b0}};
      r_row_valid   <= 1'b0;
      r_row_loaded  <= 1'b0;
      r_busy        <= 1'b0;
      r_rd_en       <= 1'b0;
      r_addr        <= {FB_AW{1'b0}};
    end else begin
      r_row_loaded <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_fetch_row <= next_row;
            r_col       <= {COL_ADDR_BITS{1'b0}};
            r_rd_en     <= 1'b1;
            r_busy      <= 1'b1;
            r_addr      <= {w_sel_start, next_row, {COL_ADDR_BITS{1'b0}}};
            r_state     <= S_FETCH;
          end else begin
            r_rd_en <= 1'b0;
          end
        end
        S_FETCH: begin
          if (r_col == COL_LAST) begin
            r_rd_en <= 1'b0;
            r_state <= S_DRAIN;
          end else begin
            r_col  <= w_col_nxt;
            r_addr <= {w_front_sel, r_fetch_row, w_col_nxt};
          end
        end
        S_DRAIN: begin
          r_state <= S_COMMIT;
        end
        S_COMMIT: begin
          r_row_out     <= r_shadow;
          r_fetched_row <= r_fetch_row;
          r_row_valid   <= 1'b1;
          r_row_loaded  <= 1'b1;
          r_busy        <= 1'b0;
          r_state       <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Read pipeline: data for the address issued two edges ago lands in the shadow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cap_v   <= 1'b0;
      r_cap_col <= {COL_ADDR_BITS{1'b0}};
      r_shadow  <= {ROW_DAT_WIDTH{1'b0}};
    end else begin
      r_cap_v   <= r_rd_en;
      r_cap_col <= r_col;
      if (r_cap_v) begin
        for (int k = 0; k < COLOR_COUNT; k++) begin
          r_shadow[k*COLOR_DAT_WIDTH + int'(r_cap_col)*COLOR_BITS +: COLOR_BITS]
            <= fb_rd_data[k*COLOR_BITS +: COLOR_BITS];
        end
      end else begin
        r_shadow <= r_shadow;
      end
    end
  end

  assign row_out    = r_row_out;
  assign row_valid  = r_row_valid;
  assign row_loaded = r_row_loaded;
  assign busy       = r_busy;
  assign fb_rd_en   = r_rd_en;
  assign fb_addr    = r_addr;
  assign front_sel  = w_front_sel;

endmodule

// File: tb/tb_hub_row_fetch.sv
// Directed bench for hub_row_fetch. A small RAM model answers reads one edge
// after sampling. Expected rows are rebuilt from the same pixel formula that
// the RAM model uses, so they do not depend on anything the DUT produces.
module tb_hub_row_fetch;

`ifdef FB_DOUBLE_BUF_EN
  localparam logic SWP = 1'b1;
`else
  localparam logic SWP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   next_row = 4'd0;
  logic [767:0] row_out;
  logic         row_valid, row_loaded, busy, fb_rd_en, swap_ack, front_sel;
  logic [10:0]  fb_addr;
  logic [11:0]  fb_rd_data = 12'h000;
  logic         swap_req = 1'b0;
  logic         cmode = 1'b1;
  int           nvec = 0;
  int           nfail = 0;

  always #5 clk = ~clk;

  hub_row_fetch dut (
    .clk(clk), .rst_n(rst_n), .next_row(next_row), .row_out(row_out),
    .row_valid(row_valid), .row_loaded(row_loaded), .busy(busy),
    .fb_rd_en(fb_rd_en), .fb_addr(fb_addr), .fb_rd_data(fb_rd_data),
    .swap_req(swap_req), .swap_ack(swap_ack), .front_sel(front_sel)
  );

  function automatic logic [11:0] pix(input logic m, input logic [10:0] a);
    logic [11:0] t;
    t = {1'b0, a} * 12'd37;
    return m ? 12'hA00 : (t ^ 12'h3C5);
  endfunction

  function automatic logic [767:0] model_row(input logic m, input logic s, input logic [3:0] r);
    logic [767:0] v;
    logic [11:0]  p;
    v = '0;
    for (int c = 0; c < 64; c++) begin
      p = pix(m, {s, r, 6'(c)});
      for (int k = 0; k < 3; k++) v[k*256 + c*4 +: 4] = p[k*4 +: 4];
    end
    return v;
  endfunction

  // RAM model: samples strobe/address at an edge, returns data after it.
  always @(posedge clk) if (fb_rd_en) fb_rd_data <= pix(cmode, fb_addr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [767:0] obs, input logic [767:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " row_out"},    row_out, 768'(0));
    chk({tag, " row_valid"},  768'(row_valid), 768'(0));
    chk({tag, " row_loaded"}, 768'(row_loaded), 768'(0));
    chk({tag, " busy"},       768'(busy), 768'(0));
    chk({tag, " fb_rd_en"},   768'(fb_rd_en), 768'(0));
    chk({tag, " fb_addr"},    768'(fb_addr), 768'(0));
    chk({tag, " swap_ack"},   768'(swap_ack), 768'(0));
    chk({tag, " front_sel"},  768'(front_sel), 768'(0));
  endtask

  // One complete fetch, E0..E66, starting at the next edge.
  task automatic run_fetch(input logic [3:0] row, input logic sel, input logic ack,
                           input int chg_at, input logic [3:0] chg_row, input logic chg_swp,
                           input logic [767:0] prev);
    for (int e = 0; e <= 66; e++) begin
      tick();
      if (e == 0) begin
        chk($sformatf("r%0d start rd_en", row), 768'(fb_rd_en), 768'(1));
        chk($sformatf("r%0d start busy", row), 768'(busy), 768'(1));
        chk($sformatf("r%0d swap_ack", row), 768'(swap_ack), 768'(ack));
        chk($sformatf("r%0d front_sel", row), 768'(front_sel), 768'(sel));
        chk($sformatf("r%0d loaded low", row), 768'(row_loaded), 768'(0));
        chk($sformatf("r%0d row_out held e0", row), row_out, prev);
      end
      if (e == 1) chk($sformatf("r%0d ack pulse end", row), 768'(swap_ack), 768'(0));
      if (e <= 63) chk($sformatf("r%0d addr e%0d", row, e), 768'(fb_addr), 768'({sel, row, 6'(e)}));
      if (e == 64) begin
        chk($sformatf("r%0d rd_en drop", row), 768'(fb_rd_en), 768'(0));
        chk($sformatf("r%0d busy e64", row), 768'(busy), 768'(1));
      end
      if (e == 65) chk($sformatf("r%0d row_out held e65", row), row_out, prev);
      if (e == 66) begin
        chk($sformatf("r%0d commit row", row), row_out, model_row(cmode, sel, row));
        chk($sformatf("r%0d valid", row), 768'(row_valid), 768'(1));
        chk($sformatf("r%0d loaded", row), 768'(row_loaded), 768'(1));
        chk($sformatf("r%0d busy done", row), 768'(busy), 768'(0));
      end
      if (e == chg_at) begin
        next_row = chg_row;
        swap_req = chg_swp;
      end
    end
  endtask

  initial begin
    logic [767:0] a_row;
    a_row = {{64{4'hA}}, 512'h0};

    // Reset held with toggling inputs.
    rst_n = 1'b0; next_row = 4'd7; swap_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      next_row = next_row + 4'd1;
      swap_req = ~swap_req;
    end
    chk_zero("reset");

    // Release with row 0 wanted: the first fetch starts at the next edge.
    swap_req = 1'b0; next_row = 4'd0; cmode = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    run_fetch(4'd0, 1'b0, 1'b0, -1, 4'd0, 1'b0, 768'(0));
    chk("A00 pattern", row_out, a_row);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle rd_en", 768'(fb_rd_en), 768'(0));
      chk("idle loaded", 768'(row_loaded), 768'(0));
      chk("idle busy", 768'(busy), 768'(0));
    end

    // Row 3 fetch with next_row moving to 4 at E10, then the row-4 fetch.
    cmode = 1'b0; next_row = 4'd3;
    run_fetch(4'd3, 1'b0, 1'b0, 10, 4'd4, 1'b0, a_row);
    run_fetch(4'd4, 1'b0, 1'b0, -1, 4'd0, 1'b0, model_row(1'b0, 1'b0, 4'd3));

    // Swap requested during row 5; applied at the row-0 start only.
    next_row = 4'd5; swap_req = 1'b1;
    run_fetch(4'd5, 1'b0, 1'b0, 5, 4'd0, 1'b0, model_row(1'b0, 1'b0, 4'd4));
    run_fetch(4'd0, SWP, SWP, 10, 4'd1, 1'b0, model_row(1'b0, 1'b0, 4'd5));
    for (int r = 1; r <= 15; r++) begin
      run_fetch(4'(r), SWP, 1'b0, 10, (r == 15) ? 4'd15 : 4'(r + 1), 1'b0,
                model_row(1'b0, SWP, 4'(r - 1)));
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("frame end idle", 768'(fb_rd_en), 768'(0));
    end

    // Level swap request held through a row-0 fetch.
    swap_req = 1'b1; next_row = 4'd0;
    run_fetch(4'd0, 1'b0, SWP, 10, 4'd0, 1'b0, model_row(1'b0, SWP, 4'd15));

    // Reset asserted at E30 of a row-9 fetch.
    next_row = 4'd9;
    for (int e = 0; e <= 30; e++) begin
      tick();
      if (e == 0) chk("r9 pre-reset start", 768'(fb_rd_en), 768'(1));
    end
    #1 rst_n = 1'b0;
    #1 chk_zero("mid-fetch reset");
    #1 rst_n = 1'b1;
    run_fetch(4'd9, 1'b0, 1'b0, -1, 4'd0, 1'b0, 768'(0));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
